// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the I/D bus arbiter of mips_cpu_bus.
// Used by mips_arb_pick and mips_bus_arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // Wide enough for any supported DATA_W; users slice the low DATA_W/8 bits.
    localparam logic [63:0] BE_ALL = '1;

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational winner select between the fetch (I) and load/store (D) ports.
// Optional feature macro: MIPS_ARB_ROUND_ROBIN_EN (alternate on ties).
module mips_arb_pick
    import mips_bus_pkg::*;
(
    input  logic i_i_req,
    input  logic i_d_req,
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    input  logic i_last_grant,
`endif
    output logic o_valid,
    output logic o_winner
);

    always_comb begin
        o_valid  = i_i_req | i_d_req;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        // On a tie, hand the bus to whichever port did not win last time.
        if (i_i_req && i_d_req)
            o_winner = (i_last_grant == PORT_D) ? PORT_I : PORT_D;
        else
            o_winner = i_d_req ? PORT_D : PORT_I;
`else
        o_winner = i_d_req ? PORT_D : PORT_I;
`endif
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-port arbiter sharing one Avalon-style bus between fetch (I) and load/store (D).
// Optional feature macro: MIPS_ARB_ROUND_ROBIN_EN (round-robin tie break instead of D-first).
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     i_address,
    input  logic                  i_read,
    output logic                  i_waitrequest,
    output logic [DATA_W-1:0]     i_readdata,

    input  logic [ADDR_W-1:0]     d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [DATA_W-1:0]     d_writedata,
    input  logic [DATA_W/8-1:0]   d_byteenable,
    output logic                  d_waitrequest,
    output logic [DATA_W-1:0]     d_readdata,

    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic [DATA_W/8-1:0]   byteenable,
    input  logic                  waitrequest,
    input  logic [DATA_W-1:0]     readdata,

    output logic                  grant_d
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t r_state, w_state_nx;
    arb_port_t  r_owner, w_owner_nx;
    logic       w_d_req;
    logic       w_pick_vld;
    logic       w_pick_d;

    assign w_d_req = d_read | d_write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    arb_port_t r_last_grant;

    always_ff @(posedge clk) begin
        if (!reset)
            r_last_grant <= PORT_D;
        else if (r_state == IDLE && w_pick_vld)
            r_last_grant <= arb_port_t'(w_pick_d);
    end
`endif

    mips_arb_pick u_pick (
        .i_i_req      (i_read),
        .i_d_req      (w_d_req),
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        .i_last_grant (r_last_grant),
`endif
        .o_valid      (w_pick_vld),
        .o_winner     (w_pick_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= PORT_I;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_owner_nx    = r_owner;
        address       = '0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        byteenable    = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = '0;
        d_readdata    = '0;
        grant_d       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_owner_nx = arb_port_t'(w_pick_d);
                    w_state_nx = w_pick_d ? OWN_D : OWN_I;
                end
            end
            OWN_I: begin
                address    = i_address;
                read       = i_read;
                byteenable = BE_ALL[BE_W-1:0];
                if (!waitrequest)
                    w_state_nx = i_read ? RESP : IDLE;
            end
            OWN_D: begin
                grant_d    = 1'b1;
                address    = d_address;
                write      = d_write;
                // A store wins over a simultaneous load request.
                read       = d_read & ~d_write;
                writedata  = d_writedata;
                byteenable = d_byteenable;
                if (!waitrequest) begin
                    if (d_write) begin
                        d_waitrequest = 1'b0;
                        w_state_nx    = IDLE;
                    end else if (d_read) begin
                        w_state_nx    = RESP;
                    end else begin
                        w_state_nx    = IDLE;
                    end
                end
            end
            RESP: begin
                w_state_nx = IDLE;
                if (r_owner == PORT_D) begin
                    grant_d       = 1'b1;
                    d_waitrequest = 1'b0;
                    d_readdata    = readdata;
                end else begin
                    i_waitrequest = 1'b0;
                    i_readdata    = readdata;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter; cycle 0 is the request-visible cycle.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        grant_d;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    localparam bit FIRST_D = 1'b0;
`else
    localparam bit FIRST_D = 1'b1;
`endif

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata),
        .grant_d(grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        i_address = '0; i_read = 0; d_address = '0; d_read = 0; d_write = 0;
        d_writedata = '0; d_byteenable = '0; waitrequest = 0; readdata = '0;
    endtask

    task automatic drive_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        d_write = 1; d_address = 32'h44; d_writedata = 32'h1111_2222; d_byteenable = 4'hF;
        drive_edge(); drive_edge();
        @(negedge clk);
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dut.r_state, IDLE); end
        n_tests++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL rst_rw got=%b%b exp=00", read, write); end
        n_tests++; if (address !== 32'h0 || writedata !== 32'h0) begin n_fail++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", address, writedata); end
        n_tests++; if (byteenable !== 4'h0) begin n_fail++; $display("FAIL rst_be got=%h exp=0", byteenable); end
        n_tests++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_wait got=%b%b exp=11", i_waitrequest, d_waitrequest); end
        n_tests++; if (grant_d !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%b exp=0", grant_d); end
        n_tests++; if (i_readdata !== 32'h0 || d_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_readdata, d_readdata); end
        drive_edge();
        clear_inputs();
        reset = 1;
        drive_edge();
    endtask

    task automatic test_i_read();
        drive_edge();
        i_read = 1; i_address = 32'h0000_0010; readdata = 32'h1234_5678; waitrequest = 0;
        @(negedge clk);
        n_tests++; if (i_waitrequest !== 1'b1 || read !== 1'b0) begin n_fail++; $display("FAIL ir_c0 got wait=%b read=%b exp 1/0", i_waitrequest, read); end
        @(negedge clk);
        n_tests++; if (i_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ir_c1_wait got=%b exp=1", i_waitrequest); end
        n_tests++; if (read !== 1'b1 || write !== 1'b0 || address !== 32'h10 || byteenable !== 4'hF) begin n_fail++; $display("FAIL ir_c1_bus got r=%b w=%b a=%h be=%h exp 1/0/10/f", read, write, address, byteenable); end
        n_tests++; if (grant_d !== 1'b0) begin n_fail++; $display("FAIL ir_c1_grant got=%b exp=0", grant_d); end
        @(negedge clk);
        n_tests++; if (i_waitrequest !== 1'b0 || i_readdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ir_c2 got wait=%b data=%h exp 0/12345678", i_waitrequest, i_readdata); end
        n_tests++; if (read !== 1'b0 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ir_c2_idle got read=%b dwait=%b exp 0/1", read, d_waitrequest); end
        drive_edge();
        clear_inputs();
        drive_edge();
    endtask

    task automatic test_d_write();
        drive_edge();
        d_write = 1; d_address = 32'h20; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011; waitrequest = 0;
        @(negedge clk);
        n_tests++; if (d_waitrequest !== 1'b1 || write !== 1'b0) begin n_fail++; $display("FAIL dw_c0 got wait=%b write=%b exp 1/0", d_waitrequest, write); end
        @(negedge clk);
        n_tests++; if (write !== 1'b1 || read !== 1'b0 || address !== 32'h20) begin n_fail++; $display("FAIL dw_c1_cmd got w=%b r=%b a=%h exp 1/0/20", write, read, address); end
        n_tests++; if (writedata !== 32'hDEAD_BEEF || byteenable !== 4'b0011) begin n_fail++; $display("FAIL dw_c1_data got d=%h be=%h exp deadbeef/3", writedata, byteenable); end
        n_tests++; if (d_waitrequest !== 1'b0 || i_waitrequest !== 1'b1) begin n_fail++; $display("FAIL dw_c1_wait got d=%b i=%b exp 0/1", d_waitrequest, i_waitrequest); end
        n_tests++; if (grant_d !== 1'b1) begin n_fail++; $display("FAIL dw_c1_grant got=%b exp=1", grant_d); end
        drive_edge();
        clear_inputs();
        @(negedge clk);
        n_tests++; if (write !== 1'b0 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL dw_c2_idle got w=%b dwait=%b exp 0/1", write, d_waitrequest); end
        drive_edge();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2;
        a1 = FIRST_D ? 32'h80 : 32'h40;
        a2 = FIRST_D ? 32'h40 : 32'h80;
        drive_edge();
        i_read = 1; i_address = 32'h40; d_read = 1; d_address = 32'h80; d_byteenable = 4'hF;
        waitrequest = 0; readdata = 32'hAAAA_0001;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (read !== 1'b1 || address !== a1 || grant_d !== FIRST_D) begin n_fail++; $display("FAIL b2b_c1 got r=%b a=%h g=%b exp 1/%h/%b", read, address, grant_d, a1, FIRST_D); end
        n_tests++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL b2b_c1_wait got i=%b d=%b exp 1/1", i_waitrequest, d_waitrequest); end
        @(negedge clk);
        n_tests++; if (d_waitrequest !== !FIRST_D || i_waitrequest !== FIRST_D) begin n_fail++; $display("FAIL b2b_c2_wait got i=%b d=%b exp %b/%b", i_waitrequest, d_waitrequest, FIRST_D, !FIRST_D); end
        n_tests++; if ((FIRST_D ? d_readdata : i_readdata) !== 32'hAAAA_0001) begin n_fail++; $display("FAIL b2b_c2_data got i=%h d=%h exp aaaa0001 on first owner", i_readdata, d_readdata); end
        drive_edge();
        if (FIRST_D) d_read = 0; else i_read = 0;
        readdata = 32'hBBBB_0002;
        @(negedge clk);
        n_tests++; if (read !== 1'b0 || i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL b2b_c3_idle got r=%b i=%b d=%b exp 0/1/1", read, i_waitrequest, d_waitrequest); end
        @(negedge clk);
        n_tests++; if (read !== 1'b1 || address !== a2 || grant_d !== !FIRST_D) begin n_fail++; $display("FAIL b2b_c4 got r=%b a=%h g=%b exp 1/%h/%b", read, address, grant_d, a2, !FIRST_D); end
        @(negedge clk);
        n_tests++; if (i_waitrequest !== !FIRST_D || d_waitrequest !== FIRST_D) begin n_fail++; $display("FAIL b2b_c5_wait got i=%b d=%b exp %b/%b", i_waitrequest, d_waitrequest, !FIRST_D, FIRST_D); end
        n_tests++; if ((FIRST_D ? i_readdata : d_readdata) !== 32'hBBBB_0002) begin n_fail++; $display("FAIL b2b_c5_data got i=%h d=%h exp bbbb0002 on second owner", i_readdata, d_readdata); end
        drive_edge();
        clear_inputs();
        drive_edge();
    endtask

    task automatic test_wait_stall();
        drive_edge();
        d_write = 1; d_address = 32'h100; d_writedata = 32'hCAFE_F00D; d_byteenable = 4'hC; waitrequest = 1;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_tests++; if (write !== 1'b1 || address !== 32'h100 || writedata !== 32'hCAFE_F00D || byteenable !== 4'hC) begin n_fail++; $display("FAIL stall_c%0d_bus got w=%b a=%h d=%h be=%h exp 1/100/cafef00d/c", c, write, address, writedata, byteenable); end
            n_tests++; if (d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL stall_c%0d_wait got=%b exp=1", c, d_waitrequest); end
        end
        drive_edge();
        waitrequest = 0;
        @(negedge clk);
        n_tests++; if (d_waitrequest !== 1'b0 || write !== 1'b1 || address !== 32'h100) begin n_fail++; $display("FAIL stall_c4 got wait=%b w=%b a=%h exp 0/1/100", d_waitrequest, write, address); end
        drive_edge();
        clear_inputs();
        drive_edge();
    endtask

    task automatic test_reset_mid();
        drive_edge();
        d_read = 1; d_address = 32'h200; d_byteenable = 4'hF; waitrequest = 1;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (read !== 1'b1 || grant_d !== 1'b1) begin n_fail++; $display("FAIL rmid_c1 got r=%b g=%b exp 1/1", read, grant_d); end
        drive_edge();
        reset = 0;
        @(negedge clk);
        drive_edge();
        @(negedge clk);
        n_tests++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL rmid_rw got r=%b w=%b exp 0/0", read, write); end
        n_tests++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rmid_wait got i=%b d=%b exp 1/1", i_waitrequest, d_waitrequest); end
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rmid_state got=%0d exp=%0d", dut.r_state, IDLE); end
        drive_edge();
        reset = 1;
        clear_inputs();
        drive_edge();
    endtask

    task automatic test_rw_both();
        drive_edge();
        d_read = 1; d_write = 1; d_address = 32'h300; d_writedata = 32'h55AA_55AA; d_byteenable = 4'hF; waitrequest = 0;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (write !== 1'b1 || read !== 1'b0) begin n_fail++; $display("FAIL rw_c1 got w=%b r=%b exp 1/0", write, read); end
        n_tests++; if (d_waitrequest !== 1'b0 || writedata !== 32'h55AA_55AA) begin n_fail++; $display("FAIL rw_c1_done got wait=%b d=%h exp 0/55aa55aa", d_waitrequest, writedata); end
        drive_edge();
        clear_inputs();
        @(negedge clk);
        n_tests++; if (read !== 1'b0 || write !== 1'b0 || d_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rw_c2_idle got r=%b w=%b wait=%b exp 0/0/1", read, write, d_waitrequest); end
        drive_edge();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_back_to_back();
        test_wait_stall();
        test_reset_mid();
        test_rw_both();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-port arbiter that shares the single Avalon-style memory bus of `mips_cpu_bus` between the instruction-fetch requester (I) and the load/store requester (D). It sits between the CPU core's fetch and memory stages and the external bus pins (`address`, `read`, `write`, `writedata`, `byteenable`, `waitrequest`, `readdata`). It serializes transfers, holds a requester stalled until its transfer completes, and routes read data back to the owning port.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`
- `clk`  in  1  bus clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `i_address`  in  ADDR_W  fetch address
- `i_read`  in  1  fetch request
- `i_waitrequest`  out  1  fetch stall; 0 only in the fetch completion cycle
- `i_readdata`  out  DATA_W  fetch data, valid when `i_waitrequest`=0
- `d_address`  in  ADDR_W  load/store address
- `d_read` / `d_write`  in  1 / 1  load / store request
- `d_writedata`  in  DATA_W  store data
- `d_byteenable`  in  DATA_W/8  store/load lanes
- `d_waitrequest`  out  1  D stall; 0 only in the D completion cycle
- `d_readdata`  out  DATA_W  load data, valid when `d_waitrequest`=0
- `address`, `read`, `write`, `writedata`, `byteenable`  out  bus master outputs
- `waitrequest`  in  1  bus stall
- `readdata`  in  DATA_W  bus read data, valid the cycle after read acceptance
- `grant_d`  out  1  1 while D owns the bus (debug)

## Operation
- FSM states: IDLE, OWN_I, OWN_D, RESP.
- IDLE: no bus activity. If any request is pending, register the winner and go to OWN_x.
- OWN_x: bus outputs mirror the owner's signals. I drives `byteenable`=all ones and `write`=0.
  - Write accepted (`waitrequest`=0): the owner's waitrequest is 0 in the same cycle, then go to IDLE.
  - Read accepted: the owner's waitrequest stays 1, then go to RESP.
  - `waitrequest`=1: hold state and outputs.
- RESP: `read`=`write`=0. The owner's waitrequest is 0 and its readdata equals bus `readdata`. Next state is IDLE.
- Only the owner port ever sees waitrequest=0. The non-owner port sees 1 whenever it requests.
- Both `d_read` and `d_write` asserted: a write is performed and `d_read` is ignored.
- Default arbitration (macro absent): fixed priority, D over I. I can be starved by back-to-back D traffic, which the core pipeline guarantees cannot occur.
- Addresses and byteenable pass through unmodified. No alignment check.
- Reset asserted mid-transfer: the FSM goes to IDLE at that edge and the transfer is abandoned; the bus is not retried.

## Timing
- Reset values:
  - State IDLE.
  - `read`=`write`=0; `address`=`writedata`=0; `byteenable`=0.
  - `i_waitrequest`=`d_waitrequest`=1.
  - `grant_d`=0; readdata outputs 0.
- Bus outputs are combinational from the registered owner plus the owner's inputs. Bus outputs are 0 in IDLE and RESP.
- Minimum latency with `waitrequest` tied 0, counted from the request-visible cycle 0:
  - Write completes in cycle 1.
  - Read completes in cycle 2.
- Each added bus-waitrequest cycle adds one cycle.
- Requesters hold address, data and strobes stable until they see waitrequest=0.

## Configuration
- `MIPS_ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request in IDLE, the port not granted last wins.
  - The last-grant register resets to D, so I wins the first tie.
  - A single requester always wins.
- Not defined: fixed D-over-I priority. The last-grant register is not instantiated.

## Structure
- Package `mips_bus_pkg`:
  - `arb_state_t` enum (IDLE, OWN_I, OWN_D, RESP)
  - `arb_port_t` enum (PORT_I, PORT_D)
  - `BE_ALL` constant, all-ones byteenable
- Sub-module `mips_arb_pick`: combinational winner select from `i_req`, `d_req` and `last_grant`. Its round-robin path is compiled under the macro.

## Test plan
- `i_read` at 0x0000_0010, `waitrequest`=0, bus returns 0x1234_5678 the next cycle → `i_waitrequest` 1,1,0 and `i_readdata`=0x1234_5678 in cycle 2.
- `d_write` at 0x20, data 0xDEAD_BEEF, byteenable 0b0011 → `write`=1 with those values in cycle 1, `d_waitrequest`=0 in cycle 1, `i_waitrequest` held 1.
- `i_read` and `d_read` together, macro absent → D served first (cycles 1–2), I served in cycles 4–5. With the macro defined, I is served first.
- Bus `waitrequest`=1 for 3 cycles during D write → owner stall extends 3 cycles and bus outputs stay stable.
- `reset`=0 asserted during OWN_D → next cycle `read`=`write`=0, both waitrequests 1, state IDLE.
- `d_read` and `d_write` both high → bus `write`=1, `read`=0.
